// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// Contents: fetch FSM state encoding, instruction/PC width, PC increment,
//           and a helper that flags a redirect target not on a 4-byte boundary.
package fetch_pkg;

    localparam int unsigned ILEN    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        VALID
    } fetch_state_t;

    // Any nonzero low bit means the target cannot hold a 32-bit instruction.
    function automatic logic is_misaligned(input logic [ILEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Groups the instruction-memory and decode handshake signals of the fetch stage.
// Signals:
//   imem_req/imem_addr    request side toward instruction memory
//   imem_ack/imem_rdata   memory accept and same-cycle instruction word
//   instr_valid/instr/instr_pc  instruction presented to decode
//   instr_ready           decode consumes the instruction
// Modports: master = fetch sequencer, slave = memory + decode side.
interface fetch_sequencer_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [ILEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [ILEN-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready
    );

endinterface

// File: rtl/fetch_sequencer_perf_cnt.sv
// Saturating event counter used for fetch statistics (built only when
// FETCH_PERF_CNT_EN is defined in the top).
// Ports:
//   clk     clock
//   rst     asynchronous active-low reset, clears the count
//   i_inc   count one event this cycle
//   o_cnt   current count, sticks at all-ones
module fetch_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner and single-outstanding instruction fetch sequencer.
// Applies branch/jump redirects; a misaligned target is replaced by TRAP_VEC.
// Optional macro: FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt counters.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   stall             holds the sequencer in IDLE/VALID
//   redirect(_pc)     one-cycle redirect pulse and its target
//   bus               imem request/ack and decode valid/ready (master)
//   pc                next address to fetch
//   misalign_trap     one-cycle pulse when TRAP_VEC was substituted
//   fetch_cnt         accepted instructions        (FETCH_PERF_CNT_EN)
//   flush_cnt         discarded fetches            (FETCH_PERF_CNT_EN)
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [ILEN-1:0]      redirect_pc,
    fetch_sequencer_if.master    bus,
    output logic [ILEN-1:0]      pc,
    output logic                 misalign_trap
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     fetch_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    fetch_state_t    r_state;
    logic [ILEN-1:0] r_pc;
    logic [ILEN-1:0] r_pc_pend;
    logic [ILEN-1:0] r_instr;
    logic [ILEN-1:0] r_instr_pc;
    logic            r_trap;

    logic [ILEN-1:0] w_tgt;
    logic            w_ack;

    assign w_tgt = is_misaligned(redirect_pc) ? TRAP_VEC : redirect_pc;
    assign w_ack = bus.imem_ack;

    // Fetch FSM: PC, pending redirect target and the presented instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_pc_pend  <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_trap     <= 1'b0;
        end else begin
            // Every state accepts a redirect, so the trap flag is state-independent.
            r_trap <= redirect && is_misaligned(redirect_pc);
            case (r_state)
                IDLE: begin
                    if (redirect) begin
                        r_pc <= w_tgt;
                    end else if (!stall) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_ack) begin
                        if (redirect) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_instr    <= bus.imem_rdata;
                            r_instr_pc <= r_pc;
                            r_pc       <= r_pc + ILEN'(PC_STEP);
                            r_state    <= VALID;
                        end
                    end else if (redirect) begin
                        // Address must stay stable until ack; park the target.
                        r_pc_pend <= w_tgt;
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_ack) begin
                        r_pc    <= redirect ? w_tgt : r_pc_pend;
                        r_state <= REQ;
                    end else if (redirect) begin
                        r_pc_pend <= w_tgt;
                    end
                end
                VALID: begin
                    if (redirect) begin
                        r_pc    <= w_tgt;
                        r_state <= REQ;
                    end else if (bus.instr_ready && !stall) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake strobes decode directly from the state register.
    assign bus.imem_req    = (r_state == REQ) || (r_state == DRAIN);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = (r_state == VALID);
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign pc              = r_pc;
    assign misalign_trap   = r_trap;

`ifdef FETCH_PERF_CNT_EN
    logic w_fetch_inc;
    logic w_flush_inc;

    assign w_fetch_inc = (r_state == REQ) && w_ack && !redirect;
    assign w_flush_inc = ((r_state == REQ) && w_ack && redirect) ||
                         ((r_state == DRAIN) && w_ack);

    fetch_perf_cnt #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_fetch_inc),
        .o_cnt (fetch_cnt)
    );

    fetch_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_flush_inc),
        .o_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. Inputs change and outputs are
// sampled on the falling clock edge; the memory returns 0xC0000000 | address.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        misalign_trap;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer_if ifc ();

    assign ifc.imem_rdata = 32'hC000_0000 | ifc.imem_addr;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .bus           (ifc),
        .pc            (pc),
        .misalign_trap (misalign_trap)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", ifc.imem_req); end
        checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ifc.instr_valid); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", pc); end
        checks++; if (ifc.instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 00000000", ifc.instr); end
        checks++; if (ifc.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp 00000000", ifc.instr_pc); end
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %0b exp 0", misalign_trap); end
        rst = 1'b1;
        ifc.imem_ack = 1'b1;
        ifc.instr_ready = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL stream_req[%0d] got %0b exp 1", k, ifc.imem_req); end
            checks++; if (ifc.imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", k, ifc.imem_addr, 32'(4 * k)); end
            checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_novalid[%0d] got %0b exp 0", k, ifc.instr_valid); end
            @(negedge clk);
            checks++; if (ifc.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp 1", k, ifc.instr_valid); end
            checks++; if (ifc.instr_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_instr_pc[%0d] got %h exp %h", k, ifc.instr_pc, 32'(4 * k)); end
            checks++; if (ifc.instr !== (32'hC000_0000 | 32'(4 * k))) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", k, ifc.instr, 32'hC000_0000 | 32'(4 * k)); end
            checks++; if (pc !== 32'(4 * k + 4)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, pc, 32'(4 * k + 4)); end
            checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL stream_req_lo[%0d] got %0b exp 0", k, ifc.imem_req); end
        end
        ifc.instr_ready = 1'b0;
        ifc.imem_ack = 1'b0;
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (ifc.instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0b exp 1", k, ifc.instr_valid); end
            checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %0b exp 0", k, ifc.imem_req); end
            checks++; if (ifc.instr_pc !== 32'h8) begin errors++; $display("FAIL hold_instr_pc[%0d] got %h exp 00000008", k, ifc.instr_pc); end
            checks++; if (ifc.instr !== 32'hC000_0008) begin errors++; $display("FAIL hold_instr[%0d] got %h exp c0000008", k, ifc.instr); end
            checks++; if (pc !== 32'hC) begin errors++; $display("FAIL hold_pc[%0d] got %h exp 0000000c", k, pc); end
        end
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL hold_release_req got %0b exp 1", ifc.imem_req); end
        checks++; if (ifc.imem_addr !== 32'hC) begin errors++; $display("FAIL hold_release_addr got %h exp 0000000c", ifc.imem_addr); end
        ifc.instr_ready = 1'b0;
    endtask

    task automatic test_drain();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL drain_req got %0b exp 1", ifc.imem_req); end
        checks++; if (ifc.imem_addr !== 32'hC) begin errors++; $display("FAIL drain_addr0 got %h exp 0000000c", ifc.imem_addr); end
        checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL drain_valid0 got %0b exp 0", ifc.instr_valid); end
        @(negedge clk);
        checks++; if (ifc.imem_addr !== 32'hC) begin errors++; $display("FAIL drain_addr1 got %h exp 0000000c", ifc.imem_addr); end
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL drain_req1 got %0b exp 1", ifc.imem_req); end
        ifc.imem_ack = 1'b1;
        @(negedge clk);
        checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL drain_discard_valid got %0b exp 0", ifc.instr_valid); end
        checks++; if (ifc.instr !== 32'hC000_0008) begin errors++; $display("FAIL drain_discard_instr got %h exp c0000008", ifc.instr); end
        checks++; if (ifc.imem_addr !== 32'h40) begin errors++; $display("FAIL drain_new_addr got %h exp 00000040", ifc.imem_addr); end
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL drain_new_req got %0b exp 1", ifc.imem_req); end
        @(negedge clk);
        checks++; if (ifc.instr_valid !== 1'b1) begin errors++; $display("FAIL drain_fetch_valid got %0b exp 1", ifc.instr_valid); end
        checks++; if (ifc.instr_pc !== 32'h40) begin errors++; $display("FAIL drain_fetch_pc got %h exp 00000040", ifc.instr_pc); end
        checks++; if (ifc.instr !== 32'hC000_0040) begin errors++; $display("FAIL drain_fetch_instr got %h exp c0000040", ifc.instr); end
        ifc.imem_ack = 1'b0;
    endtask

    task automatic test_trap();
        redirect = 1'b1;
        redirect_pc = 32'h42;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL trap_pulse got %0b exp 1", misalign_trap); end
        checks++; if (ifc.imem_addr !== 32'h100) begin errors++; $display("FAIL trap_addr got %h exp 00000100", ifc.imem_addr); end
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL trap_req got %0b exp 1", ifc.imem_req); end
        checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL trap_valid got %0b exp 0", ifc.instr_valid); end
        @(negedge clk);
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL trap_one_cycle got %0b exp 0", misalign_trap); end
        checks++; if (ifc.imem_addr !== 32'h100) begin errors++; $display("FAIL trap_addr_hold got %h exp 00000100", ifc.imem_addr); end
    endtask

    task automatic test_wrap();
        ifc.imem_ack = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (ifc.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", ifc.imem_addr); end
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req got %0b exp 1", ifc.imem_req); end
        checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_discard got %0b exp 0", ifc.instr_valid); end
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL wrap_notrap got %0b exp 0", misalign_trap); end
        @(negedge clk);
        checks++; if (ifc.instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0b exp 1", ifc.instr_valid); end
        checks++; if (ifc.instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc got %h exp fffffffc", ifc.instr_pc); end
        checks++; if (ifc.instr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr got %h exp fffffffc", ifc.instr); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", pc); end
        ifc.imem_ack = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        ifc.instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL mid_req got %0b exp 1", ifc.imem_req); end
        checks++; if (ifc.imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr got %h exp 00000000", ifc.imem_addr); end
        ifc.instr_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %0b exp 0", ifc.imem_req); end
        checks++; if (ifc.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b exp 0", ifc.instr_valid); end
        checks++; if (ifc.instr_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_instr_pc got %h exp 00000000", ifc.instr_pc); end
        checks++; if (ifc.instr !== 32'h0) begin errors++; $display("FAIL mid_rst_instr got %h exp 00000000", ifc.instr); end
        stall = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stall_idle();
        @(negedge clk);
        checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle_req got %0b exp 0", ifc.imem_req); end
        redirect = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL idle_redirect_pc got %h exp 00000080", pc); end
        checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL idle_redirect_req got %0b exp 0", ifc.imem_req); end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (ifc.imem_req !== 1'b1) begin errors++; $display("FAIL unstall_req got %0b exp 1", ifc.imem_req); end
        checks++; if (ifc.imem_addr !== 32'h80) begin errors++; $display("FAIL unstall_addr got %h exp 00000080", ifc.imem_addr); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL perf_fetch_init got %0d exp 0", fetch_cnt); end
        checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL perf_flush_init got %0d exp 0", flush_cnt); end
        rst = 1'b1;
        ifc.imem_ack = 1'b1;
        ifc.instr_ready = 1'b1;
        repeat (11) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        ifc.imem_ack = 1'b1;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        ifc.instr_ready = 1'b0;
        checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL perf_fetch got %0d exp 5", fetch_cnt); end
        checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL perf_flush got %0d exp 2", flush_cnt); end
        checks++; if (ifc.imem_addr !== 32'h200) begin errors++; $display("FAIL perf_addr got %h exp 00000200", ifc.imem_addr); end
        #2 rst = 1'b0;
        #1;
        checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL perf_fetch_rst got %0d exp 0", fetch_cnt); end
        checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL perf_flush_rst got %0d exp 0", flush_cnt); end
        checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL perf_rst_req got %0b exp 0", ifc.imem_req); end
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        ifc.imem_ack = 1'b0;
        ifc.instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_hold();
        test_drain();
        test_trap();
        test_wrap();
        test_reset_midfetch();
        test_stall_idle();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
